// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: encode stage then select/negate/shift stage, 2-cycle latency.
// Valid/ready throughout; holds output stable under backpressure and absorbs at most two pairs.
module booth_pp_gen #(
  parameter int N      = 24,
  parameter int NUM_PP = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            a,
  input  logic [N-1:0]            b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_PP*2*N-1:0]   pp_array_flat
);

  localparam int W = 2 * N;

  generate
    if ((N % 2) != 0 || NUM_PP != N / 2 + 1) begin : g_param_check
      $error("booth_pp_gen: N must be even and NUM_PP must equal N/2+1");
    end
  endgenerate

  typedef struct packed {
    logic sign;
    logic two;
    logic one;
  } booth_dig_t;

  logic                          s1_valid_q, s1_valid_d;
  logic [W-1:0]                  a_q, a_d;
  booth_dig_t [NUM_PP-1:0]       dig_q, dig_d;
  logic                          out_valid_q, out_valid_d;
  logic [NUM_PP*W-1:0]           pp_q, pp_d;

  logic                          s2_free;
  logic                          s1_adv;
  logic                          accept;
  logic [N+2:0]                  b_ext;
  booth_dig_t [NUM_PP-1:0]       dig_enc;
  logic [NUM_PP*W-1:0]           pp_gen;

  assign s2_free = !out_valid_q || out_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept  = in_valid && in_ready;

  // b shifted up by one so b[-1] is the implicit zero and the top triplet reads zeros past b[N-1].
  assign b_ext = {2'b00, b, 1'b0};

  always_comb begin
    logic [2:0] trip;
    dig_enc = '0;
    trip    = '0;
    for (int j = 0; j < NUM_PP; j++) begin
      trip            = b_ext[2*j +: 3];
      dig_enc[j].sign = trip[2];
      dig_enc[j].one  = trip[1] ^ trip[0];
      dig_enc[j].two  = (trip == 3'b011) || (trip == 3'b100);
    end
  end

  always_comb begin
    logic [W-1:0] mag;
    logic [W-1:0] sel;
    pp_gen = '0;
    mag    = '0;
    sel    = '0;
    for (int j = 0; j < NUM_PP; j++) begin
      if (dig_q[j].one) begin
        mag = a_q;
      end else if (dig_q[j].two) begin
        mag = a_q << 1;
      end else begin
        mag = '0;
      end
      // Digit 111 decodes to sign with zero magnitude; ~0+1 wraps back to zero.
      sel = dig_q[j].sign ? (~mag + W'(1)) : mag;
      pp_gen[j*W +: W] = sel << (2 * j);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    dig_d       = dig_q;
    out_valid_d = out_valid_q;
    pp_d        = pp_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = W'(a);
      dig_d      = dig_enc;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      out_valid_d = 1'b1;
      pp_d        = pp_gen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      dig_q       <= '0;
      out_valid_q <= 1'b0;
      pp_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      dig_q       <= dig_d;
      out_valid_q <= out_valid_d;
      pp_q        <= pp_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign pp_array_flat = pp_q;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: directed cases plus a randomized stream checked against an arithmetic Booth model.
module tb_booth_pp_gen;
  localparam int N      = 24;
  localparam int NUM_PP = 13;
  localparam int W      = 2 * N;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          a;
  logic [N-1:0]          b;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_PP*W-1:0]   pp_array_flat;

  booth_pp_gen #(.N(N), .NUM_PP(NUM_PP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pp_array_flat (pp_array_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] av;
    logic [N-1:0] bv;
    int           acc;
  } txn_t;

  txn_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   chk_zero = 1'b0;

  always @(posedge clk) cyc++;

  function automatic int bit_of(logic [N-1:0] v, int i);
    if (i < 0 || i >= N) return 0;
    return int'(v[i]);
  endfunction

  // Booth digit d = -2*b[2j+1] + b[2j] + b[2j-1]; PP = d*A*4^j mod 2^W.
  function automatic logic [W-1:0] model_pp(logic [N-1:0] av, logic [N-1:0] bv, int j);
    int     d;
    longint p;
    d = -2 * bit_of(bv, 2*j+1) + bit_of(bv, 2*j) + bit_of(bv, 2*j-1);
    p = (longint'(d) * longint'(av)) <<< (2 * j);
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] pp_sum(logic [NUM_PP*W-1:0] flat);
    logic [W-1:0] s;
    s = '0;
    for (int j = 0; j < NUM_PP; j++) s = s + flat[j*W +: W];
    return s;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a pair handshaked in cycle c is at the output from cycle c+2 until it is taken.
  always @(negedge clk) begin
    logic         exp_ov;
    logic [W-1:0] prod;
    if (rst) begin
      sb.delete();
      chk_zero = 1'b1;
    end else begin
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
      if (chk_zero) begin
        check("pp_zero_after_rst", 64'(pp_array_flat == '0), 64'd1);
        chk_zero = 1'b0;
      end
      if (out_valid && exp_ov) begin
        for (int j = 0; j < NUM_PP; j++)
          check($sformatf("pp%0d", j), 64'(pp_array_flat[j*W +: W]),
                64'(model_pp(sb[0].av, sb[0].bv, j)));
        prod = W'(sb[0].av) * W'(sb[0].bv);
        check("pp_sum_eq_product", 64'(pp_sum(pp_array_flat)), 64'(prod));
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{av: a, bv: b, acc: cyc});
        n_acc++;
      end
    end
  end

  task automatic send(logic [N-1:0] av, logic [N-1:0] bv);
    bit ok;
    ok       = 1'b0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [N-1:0]          pa[4];
    logic [N-1:0]          pb[4];
    logic [NUM_PP*W-1:0]   snap;
    int                    idx;
    int                    base_out;
    int                    base_acc;
    int                    guard;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    check("model_5x3_pp0", 64'(model_pp(24'd5, 24'd3, 0)), 64'h0000_FFFF_FFFF_FFFB);
    check("model_5x3_pp1", 64'(model_pp(24'd5, 24'd3, 1)), 64'h0000_0000_0000_0014);
    check("model_ff_pp0", 64'(model_pp(24'hFFFFFF, 24'hFFFFFF, 0)), 64'h0000_FFFF_FF00_0001);
    check("model_ff_pp12", 64'(model_pp(24'hFFFFFF, 24'hFFFFFF, 12)), 64'h0000_FFFF_FF00_0000);

    // 5 x 3: first edge after the handshake fills stage 1, the second loads the output.
    out_ready = 1'b1;
    send(24'd5, 24'd3);
    @(negedge clk);
    check("5x3_valid_after_1_edge", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("5x3_valid_after_2_edges", 64'(out_valid), 64'd1);
    check("5x3_pp0", 64'(pp_array_flat[0 +: W]), 64'h0000_FFFF_FFFF_FFFB);
    check("5x3_pp1", 64'(pp_array_flat[W +: W]), 64'h14);
    check("5x3_pp7", 64'(pp_array_flat[7*W +: W]), 64'h0);
    check("5x3_sum", 64'(pp_sum(pp_array_flat)), 64'd15);
    @(posedge clk); #1;

    send(24'hFFFFFF, 24'hFFFFFF);
    @(negedge clk);
    @(negedge clk);
    check("ff_pp0", 64'(pp_array_flat[0 +: W]), 64'h0000_FFFF_FF00_0001);
    check("ff_pp6", 64'(pp_array_flat[6*W +: W]), 64'h0);
    check("ff_pp12", 64'(pp_array_flat[12*W +: W]), 64'h0000_FFFF_FF00_0000);
    check("ff_sum", 64'(pp_sum(pp_array_flat)), 64'h0000_FFFF_FE00_0001);
    @(posedge clk); #1;
    wait_drain();

    base_out = n_out;
    for (int i = 0; i < 4; i++) send(24'($urandom), 24'($urandom));
    wait_drain();
    check("stream_count", 64'(n_out - base_out), 64'd4);

    // Backpressure: only two of four offered pairs may enter, and the output must not move.
    base_out = n_out;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 24'($urandom);
      pb[i] = 24'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 6; t++) begin
      a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      if (t == 2) snap = pp_array_flat;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_output_stable", 64'(pp_array_flat == snap), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && idx < 4; t++) begin
      a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("bp_all_out", 64'(n_out - base_out), 64'd4);

    // Reset with both stages occupied and an offer pending during reset.
    out_ready = 1'b0;
    for (int t = 0; t < 10 && sb.size() < 2; t++) begin
      a = 24'($urandom); b = 24'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(24'($urandom), 24'($urandom));
    wait_drain();

    // Random traffic; corner operands mixed in.
    base_out = n_out;
    base_acc = n_acc;
    guard    = 0;
    while ((n_acc - base_acc) < 10000 && guard < 60000) begin
      case ($urandom_range(0, 7))
        0: a = '0;
        1: a = '1;
        default: a = 24'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        default: b = 24'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("rand_accept_count", 64'(n_acc - base_acc), 64'd10000);
    check("rand_out_count", 64'(n_out - base_out), 64'(n_acc - base_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
